// File: rtl/slot_reel_ctrl_pkg.sv
// Shared types and constants for the slot reel controller.
package slot_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SPIN   = 2'd1,
        ST_RESULT = 2'd2
    } state_e;

    localparam int              DIGIT_W       = 4;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX  = 4'd9;

    // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10.
    localparam logic [15:0]     LFSR_SEED_DEF = 16'hACE1;
    localparam logic [15:0]     LFSR_TAPS     = 16'hB400;

endpackage

// File: rtl/slot_reel_ctrl_reel.sv
// One decimal reel: holds a digit 0..9, advances by 1 or 2 per step while running.
module slot_reel
    import slot_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               step,
    input  logic               adv2,
    input  logic               load0,
    output logic [DIGIT_W-1:0] digit
);

    localparam logic [DIGIT_W-1:0] DIGIT_MOD = DIGIT_MAX + 1'b1;

    logic [DIGIT_W-1:0] r_digit;
    logic [DIGIT_W-1:0] w_inc;
    logic [DIGIT_W-1:0] w_sum;
    logic [DIGIT_W-1:0] w_next;

    // Sum never exceeds 11, so the plain 4-bit add cannot overflow before the wrap.
    always_comb begin
        w_inc  = {{(DIGIT_W-1){1'b0}}, 1'b1} + {{(DIGIT_W-1){1'b0}}, adv2};
        w_sum  = r_digit + w_inc;
        w_next = (w_sum > DIGIT_MAX) ? (w_sum - DIGIT_MOD) : w_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_digit <= '0;
        end else if (load0) begin
            r_digit <= '0;
        end else if (run && step) begin
            r_digit <= w_next;
        end
    end

    assign digit = r_digit;

endmodule

// File: rtl/slot_reel_ctrl.sv
// Spin sequencer: gates spins on bet/credit, steps three reels, stops them in turn and publishes won.
module slot_reel_ctrl
    import slot_pkg::*;
#(
    parameter int          SPIN_TICKS = 4,
    parameter int          SPIN_STEPS = 8,
    parameter int          STOP_GAP   = 3,
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter int          RIG        = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spin,
    input  logic [3:0] bet,
    input  logic [3:0] sto,
    output logic       pause,
    output logic       won,
    output logic [3:0] reel0,
    output logic [3:0] reel1,
    output logic [3:0] reel2,
    output logic       reject,
    output logic       done
);

    localparam int TOTAL  = SPIN_STEPS + 2 * STOP_GAP;
    localparam int STEP_W = $clog2(TOTAL + 1);
    localparam int TICK_W = (SPIN_TICKS > 1) ? $clog2(SPIN_TICKS) : 1;

    localparam logic [15:0]       SEED_EFF  = (SEED == 16'h0000) ? LFSR_SEED_DEF : SEED;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SPIN_TICKS - 1);
    localparam logic [STEP_W-1:0] STEP_END  = STEP_W'(TOTAL);

    state_e              r_state;
    logic                r_spin_q;
    logic [15:0]         r_lfsr;
    logic [TICK_W-1:0]   r_tick;
    logic [STEP_W-1:0]   r_step;
    logic                r_won;
    logic                r_reject;
    logic                r_done;

    logic                w_spin_re;
    logic                w_bet_ok;
    logic                w_idle;
    logic                w_accept;
    logic                w_step;
    logic                w_load0;
    logic                w_fb;
    logic [STEP_W-1:0]   w_step_nx;
    logic [2:0][DIGIT_W-1:0] w_digit;

    always_comb begin
        w_spin_re = spin & ~r_spin_q;
        w_bet_ok  = (bet != 4'd0) && (bet <= sto);
        w_idle    = (r_state == ST_IDLE);
        w_accept  = w_idle && w_spin_re && w_bet_ok;
        w_step    = (r_state == ST_SPIN) && (r_tick == TICK_LAST);
        w_load0   = (RIG != 0) && w_accept;
        w_fb      = ^(r_lfsr & LFSR_TAPS);
        w_step_nx = r_step + 1'b1;
    end

    // A reel runs while the step count is below its own stop point; stops are staggered by STOP_GAP.
    for (genvar k = 0; k < 3; k++) begin : g_reel
        localparam logic [STEP_W-1:0] STOP_K = STEP_W'(SPIN_STEPS + k * STOP_GAP);

        logic w_run;
        logic w_adv2;

        always_comb begin
            w_run  = (r_state == ST_SPIN) && (r_step < STOP_K);
            w_adv2 = (RIG != 0) ? 1'b0 : r_lfsr[k];
        end

        slot_reel u_reel (
            .clk   (clk),
            .rst   (rst),
            .run   (w_run),
            .step  (w_step),
            .adv2  (w_adv2),
            .load0 (w_load0),
            .digit (w_digit[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_spin_q <= 1'b0;
            r_lfsr   <= SEED_EFF;
            r_tick   <= '0;
            r_step   <= '0;
            r_won    <= 1'b0;
            r_reject <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_spin_q <= spin;
            r_lfsr   <= {r_lfsr[14:0], w_fb};
            r_reject <= w_idle && w_spin_re && !w_bet_ok;
            r_done   <= (r_state == ST_RESULT);
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_SPIN;
                        r_tick  <= '0;
                        r_step  <= '0;
                        r_won   <= 1'b0;
                    end
                end
                ST_SPIN: begin
                    if (w_step) begin
                        r_tick <= '0;
                        r_step <= w_step_nx;
                        if (w_step_nx == STEP_END) begin
                            r_state <= ST_RESULT;
                        end
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                ST_RESULT: begin
                    // All reels have stopped by now, so the comparison sees final digits.
                    r_won   <= (w_digit[0] == w_digit[1]) && (w_digit[1] == w_digit[2]);
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign pause  = (r_state == ST_IDLE);
    assign won    = r_won;
    assign reel0  = w_digit[0];
    assign reel1  = w_digit[1];
    assign reel2  = w_digit[2];
    assign reject = r_reject;
    assign done   = r_done;

endmodule

// File: tb/tb_slot_reel_ctrl.sv
// Bench for slot_reel_ctrl: three parameterisations share clock, reset, bet and credit.
module tb_slot_reel_ctrl;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [3:0]      bet = 4'd0;
    logic [3:0]      sto = 4'd0;
    logic [2:0]      spin_v = 3'b000;
    logic [2:0]      pause_v, won_v, rej_v, done_v;
    logic [2:0][3:0] r0_v, r1_v, r2_v;

    int checks = 0;
    int errors = 0;

    logic [15:0] lfsr_m;
    int          mr [3][3];

    always #5 clk = ~clk;

    // Reference LFSR: x^16 + x^14 + x^13 + x^11, one shift per clock.
    always @(posedge clk) begin
        if (rst) lfsr_m <= 16'hACE1;
        else     lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end

    slot_reel_ctrl #(.SPIN_TICKS(1), .SPIN_STEPS(4), .STOP_GAP(2), .SEED(16'hACE1), .RIG(1)) u_a (
        .clk(clk), .rst(rst), .spin(spin_v[0]), .bet(bet), .sto(sto),
        .pause(pause_v[0]), .won(won_v[0]), .reel0(r0_v[0]), .reel1(r1_v[0]), .reel2(r2_v[0]),
        .reject(rej_v[0]), .done(done_v[0]));

    slot_reel_ctrl #(.SPIN_TICKS(1), .SPIN_STEPS(4), .STOP_GAP(10), .SEED(16'hACE1), .RIG(1)) u_b (
        .clk(clk), .rst(rst), .spin(spin_v[1]), .bet(bet), .sto(sto),
        .pause(pause_v[1]), .won(won_v[1]), .reel0(r0_v[1]), .reel1(r1_v[1]), .reel2(r2_v[1]),
        .reject(rej_v[1]), .done(done_v[1]));

    slot_reel_ctrl #(.SPIN_TICKS(4), .SPIN_STEPS(8), .STOP_GAP(3), .SEED(16'hACE1), .RIG(0)) u_c (
        .clk(clk), .rst(rst), .spin(spin_v[2]), .bet(bet), .sto(sto),
        .pause(pause_v[2]), .won(won_v[2]), .reel0(r0_v[2]), .reel1(r1_v[2]), .reel2(r2_v[2]),
        .reject(rej_v[2]), .done(done_v[2]));

    function automatic int reel_of(input int d, input int k);
        case (k)
            0:       return int'(r0_v[d]);
            1:       return int'(r1_v[d]);
            default: return int'(r2_v[d]);
        endcase
    endfunction

    // Drives one spin on instance d and tracks the expected reel digits from the rules.
    task automatic do_spin(input int d, input int t, input int s, input int g, input bit rig,
                           input bit extra, output int low, output int rej, output int dn,
                           output logic w1);
        int n;
        int j;
        n = s + 2 * g;
        low = 0; rej = 0; dn = 0; w1 = 1'b1;
        if (rig) for (int k = 0; k < 3; k++) mr[d][k] = 0;
        @(negedge clk);
        spin_v[d] = 1'b1;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            rej += int'(rej_v[d]);
            dn  += int'(done_v[d]);
            if (pause_v[d]) break;
            low++;
            if (cyc == 1) begin
                spin_v[d] = 1'b0;
                w1 = won_v[d];
            end
            if (extra && (cyc == 3 || cyc == 6)) spin_v[d] = 1'b1;
            if (extra && (cyc == 4 || cyc == 7)) spin_v[d] = 1'b0;
            if ((cyc % t) == 0 && (cyc / t) <= n) begin
                j = cyc / t;
                for (int k = 0; k < 3; k++)
                    if (j <= s + k * g)
                        mr[d][k] = (mr[d][k] + 1 + (rig ? 0 : int'(lfsr_m[k]))) % 10;
            end
        end
        @(negedge clk);
        rej += int'(rej_v[d]);
        dn  += int'(done_v[d]);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        spin_v = 3'b000;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 3; d++) for (int k = 0; k < 3; k++) mr[d][k] = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (pause_v[d] !== 1'b1 || won_v[d] !== 1'b0 || rej_v[d] !== 1'b0 || done_v[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_flags inst %0d got pause=%b won=%b rej=%b done=%b want 1 0 0 0",
                         d, pause_v[d], won_v[d], rej_v[d], done_v[d]);
            end
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (reel_of(d, k) !== 0) begin
                    errors++;
                    $display("FAIL reset_reel inst %0d reel %0d got %0d want 0", d, k, reel_of(d, k));
                end
            end
        end
    endtask

    // Issues one spin edge on instance 0 with the current bet/sto and expects a single reject.
    task automatic reject_attempt(input string name);
        int rc, lowc;
        rc = 0; lowc = 0;
        @(negedge clk);
        spin_v[0] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            spin_v[0] = 1'b0;
            rc   += int'(rej_v[0]);
            lowc += int'(!pause_v[0]);
        end
        checks++;
        if (rc !== 1) begin
            errors++;
            $display("FAIL %s reject pulses got %0d want 1 (bet=%0d sto=%0d)", name, rc, bet, sto);
        end
        checks++;
        if (lowc !== 0) begin
            errors++;
            $display("FAIL %s pause low cycles got %0d want 0", name, lowc);
        end
        checks++;
        if (r0_v[0] !== 4'd0 || r1_v[0] !== 4'd0 || r2_v[0] !== 4'd0) begin
            errors++;
            $display("FAIL %s reels got %0d/%0d/%0d want 0/0/0", name, r0_v[0], r1_v[0], r2_v[0]);
        end
    endtask

    task automatic test_reject();
        bet = 4'd0; sto = 4'd5;
        reject_attempt("reject_bet0");
        bet = 4'd6; sto = 4'd5;
        reject_attempt("reject_over");
        for (int i = 0; i < 4; i++) begin
            sto = 4'($urandom_range(0, 14));
            if ($urandom_range(0, 1) == 0) bet = 4'd0;
            else                           bet = 4'($urandom_range(int'(sto) + 1, 15));
            reject_attempt("reject_rand");
        end
    endtask

    task automatic test_rig_lose(input bit extra, input string name);
        int low, rej, dn;
        logic w1;
        bet = 4'd2; sto = 4'd5;
        do_spin(0, 1, 4, 2, 1'b1, extra, low, rej, dn, w1);
        checks++;
        if (low !== 9) begin errors++; $display("FAIL %s pause_low got %0d want 9", name, low); end
        checks++;
        if (r0_v[0] !== 4'd4 || r1_v[0] !== 4'd6 || r2_v[0] !== 4'd8) begin
            errors++;
            $display("FAIL %s reels got %0d/%0d/%0d want 4/6/8", name, r0_v[0], r1_v[0], r2_v[0]);
        end
        checks++;
        if (won_v[0] !== 1'b0) begin errors++; $display("FAIL %s won got %b want 0", name, won_v[0]); end
        checks++;
        if (dn !== 1) begin errors++; $display("FAIL %s done pulses got %0d want 1", name, dn); end
        checks++;
        if (rej !== 0) begin errors++; $display("FAIL %s reject pulses got %0d want 0", name, rej); end
    endtask

    task automatic test_rig_win();
        int low, rej, dn;
        logic w1;
        bet = 4'd3; sto = 4'd9;
        for (int r = 0; r < 2; r++) begin
            do_spin(1, 1, 4, 10, 1'b1, 1'b0, low, rej, dn, w1);
            checks++;
            if (low !== 25) begin errors++; $display("FAIL win pause_low got %0d want 25", low); end
            checks++;
            if (int'(r0_v[1]) !== mr[1][0] || int'(r1_v[1]) !== mr[1][1] || int'(r2_v[1]) !== mr[1][2]) begin
                errors++;
                $display("FAIL win reels got %0d/%0d/%0d want %0d/%0d/%0d",
                         r0_v[1], r1_v[1], r2_v[1], mr[1][0], mr[1][1], mr[1][2]);
            end
            checks++;
            if (won_v[1] !== 1'b1) begin errors++; $display("FAIL win won got %b want 1", won_v[1]); end
            checks++;
            if (dn !== 1) begin errors++; $display("FAIL win done pulses got %0d want 1", dn); end
            if (r == 1) begin
                checks++;
                if (w1 !== 1'b0) begin errors++; $display("FAIL win_clear won after accept got %b want 0", w1); end
            end
            repeat (6) @(negedge clk);
            checks++;
            if (won_v[1] !== 1'b1) begin errors++; $display("FAIL win_hold won got %b want 1", won_v[1]); end
        end
    endtask

    task automatic test_reset_mid_spin();
        bet = 4'd1; sto = 4'd1;
        @(negedge clk);
        spin_v[0] = 1'b1;
        repeat (3) @(negedge clk);
        spin_v[0] = 1'b0;
        checks++;
        if (pause_v[0] !== 1'b0) begin errors++; $display("FAIL mid_spin_started pause got %b want 0", pause_v[0]); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (pause_v !== 3'b111 || won_v !== 3'b000) begin
            errors++;
            $display("FAIL mid_reset pause got %b won got %b want 111 000", pause_v, won_v);
        end
        checks++;
        if (r0_v[0] !== 4'd0 || r1_v[0] !== 4'd0 || r2_v[0] !== 4'd0) begin
            errors++;
            $display("FAIL mid_reset reels got %0d/%0d/%0d want 0/0/0", r0_v[0], r1_v[0], r2_v[0]);
        end
        rst = 1'b0;
        for (int d = 0; d < 3; d++) for (int k = 0; k < 3; k++) mr[d][k] = 0;
    endtask

    task automatic test_random_rig0();
        int low, rej, dn;
        logic w1;
        bit exp_won;
        for (int i = 0; i < 20; i++) begin
            bet = 4'($urandom_range(1, 15));
            sto = 4'($urandom_range(int'(bet), 15));
            repeat ($urandom_range(0, 7)) @(negedge clk);
            do_spin(2, 4, 8, 3, 1'b0, 1'b0, low, rej, dn, w1);
            exp_won = (mr[2][0] == mr[2][1]) && (mr[2][1] == mr[2][2]);
            checks++;
            if (low !== 57) begin errors++; $display("FAIL rig0 spin %0d pause_low got %0d want 57", i, low); end
            checks++;
            if (r0_v[2] > 4'd9 || r1_v[2] > 4'd9 || r2_v[2] > 4'd9) begin
                errors++;
                $display("FAIL rig0 spin %0d range got %0d/%0d/%0d want <=9", i, r0_v[2], r1_v[2], r2_v[2]);
            end
            checks++;
            if (int'(r0_v[2]) !== mr[2][0] || int'(r1_v[2]) !== mr[2][1] || int'(r2_v[2]) !== mr[2][2]) begin
                errors++;
                $display("FAIL rig0 spin %0d reels got %0d/%0d/%0d want %0d/%0d/%0d", i,
                         r0_v[2], r1_v[2], r2_v[2], mr[2][0], mr[2][1], mr[2][2]);
            end
            checks++;
            if (won_v[2] !== exp_won) begin errors++; $display("FAIL rig0 spin %0d won got %b want %b", i, won_v[2], exp_won); end
            checks++;
            if (dn !== 1 || rej !== 0) begin
                errors++;
                $display("FAIL rig0 spin %0d done/reject got %0d/%0d want 1/0", i, dn, rej);
            end
        end
    endtask

    initial begin
        test_reset();
        test_reject();
        test_rig_lose(1'b0, "rig_lose");
        test_rig_win();
        test_rig_lose(1'b1, "spin_ignored");
        test_reset_mid_spin();
        test_random_rig0();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/slot_reel_ctrl.md
Name: slot_reel_ctrl

Overview:
- Game-side counterpart of the bet/credit keeper: it generates the pause and won signals that the keeper consumes, and it reads bet and sto back to gate spins.
- It runs one spin per accepted request: three decimal reels step, stop one after another, are compared, and then the result is published.
- It sits between the debounced spin button and the credit keeper, and it drives the reel digit displays.

Parameters:
- SPIN_TICKS, 4, clock cycles per reel step (≥1)
- SPIN_STEPS, 8, steps before reel0 stops (≥1)
- STOP_GAP, 3, extra steps between consecutive reel stops (≥1)
- SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'hACE1
- RIG, 0, test mode: 1 ignores the LFSR, so every step advances each reel by exactly 1 and all reels load 0 on accept

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high; the credit keeper shares this rst
- spin  in  1  debounced spin button, level; rising edge is detected internally
- bet  in  4  current bet from the credit keeper
- sto  in  4  current credit from the credit keeper
- pause  out  1  1 = idle, betting allowed; 0 = spin in progress
- won  out  1  result of the last completed spin, held until the next accept
- reel0  out  4  reel digit 0..9
- reel1  out  4  reel digit 0..9
- reel2  out  4  reel digit 0..9
- reject  out  1  one-cycle pulse: a spin edge was refused
- done  out  1  one-cycle pulse on the first cycle pause returns to 1

Behaviour:
- Reset values: state IDLE, pause=1, won=0, reel0..2=0, reject=0, done=0, LFSR=SEED, spin edge register=0, tick and step counters=0.
- Edge detect: spin_re = spin & ~spin_q, where spin_q is registered every cycle.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; shifts every cycle in every state.
- States: IDLE, SPIN, RESULT.
- IDLE:
  - pause=1.
  - spin_re with bet!=0 and bet<=sto → accept: next state SPIN; tick=0, step=0, won cleared to 0, all reels marked running; when RIG=1, reels load 0.
  - spin_re with bet==0 or bet>sto → reject=1 for one cycle; state unchanged.
- SPIN:
  - pause=0; spin edges are ignored, with no reject pulse.
  - tick counts 0..SPIN_TICKS-1; a step occurs on the cycle tick==SPIN_TICKS-1, then tick wraps to 0.
  - On each step, every running reel k advances by 1+lfsr[k] modulo 10 (9+1→0, 9+2→1, 8+2→0). With RIG=1 the advance is always 1.
  - After a step, the step counter increments.
  - Stops: reel0 stops when step reaches SPIN_STEPS, reel1 at SPIN_STEPS+STOP_GAP, reel2 at SPIN_STEPS+2·STOP_GAP. A stopped reel holds its value.
  - When reel2 stops, next state is RESULT.
  - Spin duration is exactly (SPIN_STEPS+2·STOP_GAP)·SPIN_TICKS cycles.
- RESULT:
  - Lasts one cycle with pause=0; won is registered as (reel0==reel1)&&(reel1==reel2).
  - Next state IDLE; done pulses in that first IDLE cycle.
  - Total pause-low time per spin = (SPIN_STEPS+2·STOP_GAP)·SPIN_TICKS+1 cycles.
- won is stable from RESULT until the next accept, so it is valid on and after the pause 0→1 transition that the keeper settles on.
- With RIG=0, reels start each spin from their previous values.
- Reset mid-spin: immediate return to the reset values (pause=1, won=0). The keeper is reset on the same rst, so no settlement occurs.
- Counter widths: tick counter clog2(SPIN_TICKS); step counter clog2(SPIN_STEPS+2·STOP_GAP+1).

Decomposition:
- Shared package slot_pkg: state enum (IDLE, SPIN, RESULT), DIGIT_W=4, DIGIT_MAX=9, default LFSR seed and tap constants.
- One sub-module: slot_reel. It holds one mod-10 digit with inputs run, step, adv2, load0 and output digit, and is instantiated three times.
- LFSR, counters and FSM live in the top module.

Test Plan:
- Reject when bet=0: rst, then bet=0, sto=5, spin edge → reject high for 1 cycle, pause stays 1, reels unchanged.
- Reject when bet>sto: bet=6, sto=5, spin edge → reject pulse, pause stays 1, no state change.
- RIG=1 lose timing: T=1, S=4, G=2, bet=2, sto=5, spin edge → pause low exactly 9 cycles; reels 4/6/8; won=0; done pulses once.
- RIG=1 win: T=1, S=4, G=10 → pause low exactly 25 cycles; reels 4/4/4; won=1 when pause rises, held until the next accept, then cleared.
- Spin during SPIN: extra spin edges mid-spin → ignored, no reject, duration unchanged. Then rst asserted mid-spin → next cycle pause=1, won=0, reels=0.
- RIG=0 default parameters: 20 spins against a golden LFSR/reel model → every reel value in 0..9; won matches the three-way equality every spin; pause-low time is 57 cycles.
